// File: rtl/fetch_execute_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: opcodes, state
// encodings and the layout of the active-high control word.
package fetch_execute_sequencer_pkg;

    // Micro-steps per instruction slot (T0..T4)
    localparam int NUM_STEPS_DEF = 5;

    // Opcodes carried in IR[7:4]
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Sequencer states; T0..T4 encode the micro-step number directly
    typedef enum logic [2:0] {
        ST_T0     = 3'd0,
        ST_T1     = 3'd1,
        ST_T2     = 3'd2,
        ST_T3     = 3'd3,
        ST_T4     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    // Active-high control word; first field is the MSB
    typedef struct packed {
        logic pc_read;
        logic pc_write;
        logic pc_inc;
        logic mar_write;
        logic ram_read;
        logic ram_write;
        logic ir_read;
        logic ir_write;
        logic a_read;
        logic a_write;
        logic b_write;
        logic alu_read;
        logic alu_sub;
        logic out_write;
    } ctrl_t;

    localparam int CW_W = 14;

    // Bit positions of each field inside the packed control word
    localparam int CW_PC_READ   = 13;
    localparam int CW_PC_WRITE  = 12;
    localparam int CW_PC_INC    = 11;
    localparam int CW_MAR_WRITE = 10;
    localparam int CW_RAM_READ  = 9;
    localparam int CW_RAM_WRITE = 8;
    localparam int CW_IR_READ   = 7;
    localparam int CW_IR_WRITE  = 6;
    localparam int CW_A_READ    = 5;
    localparam int CW_A_WRITE   = 4;
    localparam int CW_B_WRITE   = 3;
    localparam int CW_ALU_READ  = 2;
    localparam int CW_ALU_SUB   = 1;
    localparam int CW_OUT_WRITE = 0;

    // All-idle control word
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/fetch_execute_sequencer_microcode_decoder.sv
// Combinational microcode: maps (state, opcode, flags) to the control word
// for the current cycle plus the step-sequencing hints for the state register.
module microcode_decoder
    import fetch_execute_sequencer_pkg::*;
(
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic       i_carry,
    input  logic       i_zero,
    output ctrl_t      o_ctrl,
    output logic       o_is_last_step,
    output logic       o_halt_req
);

    // Decode one micro-step; every bus driver appears in at most one arm
    always_comb begin
        o_ctrl         = ctrl_idle();
        o_is_last_step = 1'b0;
        o_halt_req     = 1'b0;
        case (i_state)
            ST_T0: begin
                o_ctrl.pc_read   = 1'b1;
                o_ctrl.mar_write = 1'b1;
            end
            ST_T1: begin
                o_ctrl.ram_read = 1'b1;
                o_ctrl.ir_write = 1'b1;
                o_ctrl.pc_inc   = 1'b1;
            end
            ST_T2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        // Operand address goes to MAR; more steps follow
                        o_ctrl.ir_read   = 1'b1;
                        o_ctrl.mar_write = 1'b1;
                    end
                    OP_LDI: begin
                        o_ctrl.ir_read = 1'b1;
                        o_ctrl.a_write = 1'b1;
                        o_is_last_step = 1'b1;
                    end
                    OP_JMP: begin
                        o_ctrl.ir_read  = 1'b1;
                        o_ctrl.pc_write = 1'b1;
                        o_is_last_step  = 1'b1;
                    end
                    OP_JC: begin
                        o_ctrl.ir_read  = i_carry;
                        o_ctrl.pc_write = i_carry;
                        o_is_last_step  = 1'b1;
                    end
                    OP_JZ: begin
                        o_ctrl.ir_read  = i_zero;
                        o_ctrl.pc_write = i_zero;
                        o_is_last_step  = 1'b1;
                    end
                    OP_OUT: begin
                        o_ctrl.a_read    = 1'b1;
                        o_ctrl.out_write = 1'b1;
                        o_is_last_step   = 1'b1;
                    end
                    OP_HLT: begin
                        o_halt_req = 1'b1;
                    end
                    default: begin
                        // NOP and undefined opcodes: one idle T2
                        o_is_last_step = 1'b1;
                    end
                endcase
            end
            ST_T3: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl.ram_read = 1'b1;
                        o_ctrl.a_write  = 1'b1;
                        o_is_last_step  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_ctrl.ram_read = 1'b1;
                        o_ctrl.b_write  = 1'b1;
                        o_ctrl.alu_sub  = (i_opcode == OP_SUB);
                    end
                    OP_STA: begin
                        o_ctrl.a_read    = 1'b1;
                        o_ctrl.ram_write = 1'b1;
                        o_is_last_step   = 1'b1;
                    end
                    default: begin
                        // Unreachable for a stable IR; recover to fetch
                        o_is_last_step = 1'b1;
                    end
                endcase
            end
            ST_T4: begin
                if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                    o_ctrl.alu_read = 1'b1;
                    o_ctrl.a_write  = 1'b1;
                    o_ctrl.alu_sub  = (i_opcode == OP_SUB);
                end
                o_is_last_step = 1'b1;
            end
            default: begin
                // HALTED (and any illegal encoding) drives nothing
                o_ctrl = ctrl_idle();
            end
        endcase
    end

endmodule

// File: rtl/fetch_execute_sequencer.sv
// Control unit for the 8-bit shared-bus CPU: holds the micro-step state and
// turns the decoded control word into gated, active-low register strobes.
module fetch_execute_sequencer
    import fetch_execute_sequencer_pkg::*;
#(
    parameter int NUM_STEPS = NUM_STEPS_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic [3:0] i_opcode,
    input  logic       i_carry,
    input  logic       i_zero,
    output logic       o_pc_read_n,
    output logic       o_pc_write_n,
    output logic       o_pc_inc_n,
    output logic       o_mar_write_n,
    output logic       o_ram_read_n,
    output logic       o_ram_write_n,
    output logic       o_ir_read_n,
    output logic       o_ir_write_n,
    output logic       o_a_read_n,
    output logic       o_a_write_n,
    output logic       o_b_write_n,
    output logic       o_alu_read_n,
    output logic       o_alu_sub,
    output logic       o_out_write_n,
    output logic [2:0] o_step,
    output logic       o_halted
);

    localparam int STEP_W = $clog2(NUM_STEPS);

    state_t            r_state;
    ctrl_t             w_ctrl;
    logic [CW_W-1:0]   w_ctrl_vec;
    logic [CW_W-1:0]   w_ctrl_gated;
    logic              w_is_last;
    logic              w_halt_req;
    logic              w_gate;
    logic [STEP_W-1:0] w_step;

    microcode_decoder u_decoder (
        .i_state        (r_state),
        .i_opcode       (i_opcode),
        .i_carry        (i_carry),
        .i_zero         (i_zero),
        .o_ctrl         (w_ctrl),
        .o_is_last_step (w_is_last),
        .o_halt_req     (w_halt_req)
    );

    // Advance the micro-step; reset wins, HALTED is sticky, enable freezes
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_T0;
        end else if (r_state == ST_HALTED) begin
            r_state <= ST_HALTED;
        end else if (i_enable) begin
            if (w_halt_req) begin
                r_state <= ST_HALTED;
            end else if (w_is_last) begin
                r_state <= ST_T0;
            end else begin
                r_state <= state_t'(r_state + 3'd1);
            end
        end
    end

    // Strobes only fire while out of reset, enabled and not halted, so a
    // reset or freeze in the middle of a step never leaves a partial strobe
    assign w_gate     = i_reset_n & i_enable & (r_state != ST_HALTED);
    assign w_ctrl_vec = w_ctrl;

    generate
        for (genvar gi = 0; gi < CW_W; gi++) begin : g_gate
            assign w_ctrl_gated[gi] = w_ctrl_vec[gi] & w_gate;
        end
    endgenerate

    assign o_pc_read_n   = ~w_ctrl_gated[CW_PC_READ];
    assign o_pc_write_n  = ~w_ctrl_gated[CW_PC_WRITE];
    assign o_pc_inc_n    = ~w_ctrl_gated[CW_PC_INC];
    assign o_mar_write_n = ~w_ctrl_gated[CW_MAR_WRITE];
    assign o_ram_read_n  = ~w_ctrl_gated[CW_RAM_READ];
    assign o_ram_write_n = ~w_ctrl_gated[CW_RAM_WRITE];
    assign o_ir_read_n   = ~w_ctrl_gated[CW_IR_READ];
    assign o_ir_write_n  = ~w_ctrl_gated[CW_IR_WRITE];
    assign o_a_read_n    = ~w_ctrl_gated[CW_A_READ];
    assign o_a_write_n   = ~w_ctrl_gated[CW_A_WRITE];
    assign o_b_write_n   = ~w_ctrl_gated[CW_B_WRITE];
    assign o_alu_read_n  = ~w_ctrl_gated[CW_ALU_READ];
    assign o_alu_sub     =  w_ctrl_gated[CW_ALU_SUB];
    assign o_out_write_n = ~w_ctrl_gated[CW_OUT_WRITE];

    // Debug step: the state encoding, forced to zero while reset is held
    assign w_step   = i_reset_n ? STEP_W'(r_state) : '0;
    assign o_step   = 3'(w_step);
    assign o_halted = (r_state == ST_HALTED);

endmodule

// File: doc/fetch_execute_sequencer.md
Name: fetch_execute_sequencer

Overview:
- Control unit for the 8-bit shared-bus CPU.
- Steps through fetch/execute micro-steps and drives the active-low read/write/inc strobes of the program counter, MAR, RAM, IR, A, B, ALU and output registers.
- Guarantees at most one bus driver per cycle.
- Sits between the instruction register (opcode source) and every bus-attached register.

Parameters:
- NUM_STEPS, 5, micro-steps per instruction slot (T0..T4); step counter width is clog2(NUM_STEPS).

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge
- i_reset_n  in  1  synchronous, active-low reset
- i_enable  in  1  1 = advance; 0 = freeze state and deassert all strobes
- i_opcode  in  4  IR[7:4], valid from T2 onward
- i_carry  in  1  ALU carry flag
- i_zero  in  1  ALU zero flag
- o_pc_read_n  out  1  PC drives bus
- o_pc_write_n  out  1  PC loads from bus
- o_pc_inc_n  out  1  PC increments
- o_mar_write_n  out  1  MAR loads from bus
- o_ram_read_n  out  1  RAM drives bus
- o_ram_write_n  out  1  RAM loads from bus
- o_ir_read_n  out  1  IR drives operand (low nibble, zero-extended)
- o_ir_write_n  out  1  IR loads from bus
- o_a_read_n  out  1  A drives bus
- o_a_write_n  out  1  A loads from bus
- o_b_write_n  out  1  B loads from bus
- o_alu_read_n  out  1  ALU result drives bus
- o_alu_sub  out  1  1 = subtract
- o_out_write_n  out  1  output register loads from bus
- o_step  out  3  current micro-step (debug)
- o_halted  out  1  1 in HALTED

Behaviour:
- States: T0, T1, T2, T3, T4, HALTED. The registered state is the only sequential element; strobes decode combinationally from state, i_opcode and flags.
- Reset: i_reset_n low at an edge forces T0 and o_halted=0. While i_reset_n is low, all *_n strobes are forced to 1, o_alu_sub=0, o_step=0. Reset mid-instruction abandons the instruction with no partial strobes.
- i_enable=0: state holds; all strobes deasserted. Resumes at the same step when i_enable returns to 1.
- Fetch (all opcodes):
  - T0: pc_read, mar_write.
  - T1: ram_read, ir_write, pc_inc.
- Execute (flags sampled combinationally during T2 only):
  - 0x0 NOP: T2 idle.
  - 0x1 LDA: T2 ir_read+mar_write; T3 ram_read+a_write.
  - 0x2 ADD: T2 ir_read+mar_write; T3 ram_read+b_write; T4 alu_read+a_write.
  - 0x3 SUB: as ADD; o_alu_sub=1 during T3 and T4.
  - 0x4 STA: T2 ir_read+mar_write; T3 a_read+ram_write.
  - 0x5 LDI: T2 ir_read+a_write.
  - 0x6 JMP: T2 ir_read+pc_write.
  - 0x7 JC: T2 ir_read+pc_write if i_carry=1, else idle.
  - 0x8 JZ: T2 ir_read+pc_write if i_zero=1, else idle.
  - 0xE OUT: T2 a_read+out_write.
  - 0xF HLT: T2 all strobes idle; next state HALTED.
  - 0x9-0xD: execute as NOP.
- Step advance: after the last active step of an opcode, next state is T0 (no dead cycle). NOP, untaken jumps and undefined opcodes use one idle T2. Instruction lengths: LDA 4, ADD/SUB 5, STA 4, one-step ops 3 cycles.
- HALTED: all strobes deasserted, o_halted=1. Left only by reset; i_enable has no effect.
- Bus invariant: at most one of pc_read, ram_read, ir_read, a_read, alu_read is low in any cycle, including while i_enable or i_reset_n toggles.
- pc_inc and pc_write are never both low in the same cycle.

Decomposition:
- Shared package: opcode constants (OP_NOP..OP_HLT), state encodings, and a control-word struct/bit-index constants for the strobe vector.
- One natural sub-module, microcode_decoder (combinational): inputs state, opcode and flags; outputs control word and an is_last_step flag. The top holds only the state register, enable/reset gating and active-low output inversion.

Test Plan:
- Reset: i_reset_n=0 for 2 cycles, then release -> all *_n=1 during reset; first enabled cycle is T0 with pc_read_n=0 and mar_write_n=0.
- ADD, opcode 0x2 -> strobes match the ADD table at T0..T4, o_alu_sub=0, then T0 on cycle 6. SUB (0x3) -> o_alu_sub=1 only at T3 and T4.
- JC with i_carry=1, then i_carry=0 -> first run pulls pc_write_n low at T2; second keeps it high. Both return to T0 after T2.
- Freeze and bus check: i_enable=0 for 3 cycles at T3 of LDA -> step holds at 3, all strobes high; resume completes ram_read+a_write. Across a random opcode stream, at most one bus driver is low per cycle.
- HLT (0xF) -> o_halted=1 from the cycle after T2; strobes stay high for 20 cycles with any i_enable; reset returns to T0.
- Reset asserted at T3 of STA -> ram_write_n never goes low; o_step=0 after the edge.
